cbfp_restore: RTL and testbench
===============================

Name: cbfp_restore

Overview:
- Inverse of the CBFP normalizer. Takes 12-bit block-floating mantissa vectors and the per-block shift index the normalizer produced for each vector.
- Rescales every lane back to the common 25-bit fixed-point format <12.13>.
- Shift indices arrive ahead of their data, because downstream FFT stages add latency, so they are buffered in an in-order exponent FIFO.
- Sits at the end of the datapath, after the last FFT stage that consumes CBFP-normalized data.

Parameters:
- MANT_W, 12, input mantissa width <6.6>
- RES_W, 25, restored output width <12.13>
- NCHAN, 16, parallel lanes per vector
- BLOCK_SIZE, 8, lanes sharing one shift index
- NBLOCKS, NCHAN/BLOCK_SIZE, number of blocks per vector
- TRUNC_VALUE, 13, normalizer truncation constant
- IDX_W, $clog2(RES_W), shift index width
- EXP_DEPTH, 8, exponent FIFO depth in entries (power of 2)

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- exp_valid  input  1  push one exponent entry
- exp_idx  input  IDX_W x NBLOCKS  per-block min index (unsigned)
- exp_ready  output  1  FIFO can accept a push
- valid_in  input  1  mantissa vector present
- in_ready  output  1  a stored exponent exists for the next vector
- data_re_in  input  signed MANT_W x NCHAN  real mantissas
- data_im_in  input  signed MANT_W x NCHAN  imaginary mantissas
- data_re_out  output  signed RES_W x NCHAN  restored real
- data_im_out  output  signed RES_W x NCHAN  restored imaginary
- valid_out  output  1  output vector valid
- exp_count  output  $clog2(EXP_DEPTH)+1  FIFO occupancy
- err_ovf  output  1  sticky: push dropped
- err_udf  output  1  sticky: vector dropped

Behaviour:
- Reset (async, rst=1): FIFO pointers and count 0; all data outputs 0; valid_out, err_ovf, err_udf 0. Reset mid-operation discards all stored exponents and any in-flight vector.
- exp_ready = (count < EXP_DEPTH) combinationally. in_ready = (count != 0). There is no bypass: an exponent pushed in cycle N is poppable from cycle N+1.
- Push occurs when exp_valid && exp_ready.
- exp_valid while full:
  - With no pop that cycle, the entry is dropped and err_ovf is set.
  - If a pop occurs in the same cycle, the push is still rejected, because exp_ready is evaluated on the current count. err_ovf is set.
- Pop occurs when valid_in && in_ready. The head entry pairs with this vector.
- valid_in while empty: the vector is dropped, err_udf is set, and no output is produced.
- Simultaneous push and pop with count between 1 and EXP_DEPTH-1: count is unchanged and both operations happen. Pointers wrap modulo EXP_DEPTH.
- Restore arithmetic, per lane ch, using idx = head.exp_idx[ch / BLOCK_SIZE]:
  - idx <= TRUNC_VALUE: out = sign-extend(in) <<< (TRUNC_VALUE - idx). The left shift is at most 13, so the result fits RES_W with no saturation.
  - idx > TRUNC_VALUE: out = sign-extend(in) >>> (idx - TRUNC_VALUE), arithmetic with floor rounding.
  - The same idx is applied to the re and im parts.
- Latency: outputs are registered, 1 cycle after an accepted vector. valid_out is high for exactly 1 cycle per accepted vector. Data outputs hold their last value when valid_out=0.
- Back-to-back accepted vectors give back-to-back outputs, one per cycle.
- exp_count is registered and updates on the clock edge after a push or pop.
- err_ovf and err_udf clear only on rst.

Test Plan:
- Reset, push idx {13,13}, then a vector with all lanes re=100, im=-100 -> 1 cycle later all out re=100, im=-100; valid_out pulses once; count back to 0.
- Push {10,20}; lane0 re=5, lane8 re=-3 -> lane0 out = 5<<3 = 40; lane8 out = -3>>>7 = -1.
- Push {0,0} with lane re=-2048 -> out = -2048<<13 = -16777216 (RES_W min), no overflow.
- Push 8 distinct entries (count=8, exp_ready=0), push a 9th -> dropped, err_ovf=1. Then 8 vectors -> outputs use the entries in push order and pointers wrap.
- valid_in with FIFO empty -> no valid_out, err_udf=1. Same-cycle push+pop at count=3 -> count stays 3.
- Assert rst mid-stream with count=4 -> outputs 0, count 0, in_ready 0 immediately.

Source files
------------

// File: rtl/cbfp_restore_if.sv
// cbfp_restore_if
// Bundles the exponent-push channel, the mantissa-vector channel, the
// restored outputs and the status flags of cbfp_restore.
//   exp_valid/exp_idx/exp_ready : push one per-block shift-index entry
//   valid_in/in_ready/data_*_in : mantissa vector, accepted when an entry is stored
//   data_*_out/valid_out        : restored <12.13> vector, one cycle later
//   exp_count, err_ovf, err_udf : FIFO occupancy and sticky drop flags
// master = producer/consumer side (testbench), slave = cbfp_restore.
interface cbfp_restore_if #(
  parameter int MANT_W      = 12,
  parameter int RES_W       = 25,
  parameter int NCHAN       = 16,
  parameter int BLOCK_SIZE  = 8,
  parameter int NBLOCKS     = NCHAN / BLOCK_SIZE,
  parameter int IDX_W       = $clog2(RES_W),
  parameter int EXP_DEPTH   = 8
);
  logic                                   exp_valid;
  logic        [NBLOCKS-1:0][IDX_W-1:0]   exp_idx;
  logic                                   exp_ready;
  logic                                   valid_in;
  logic                                   in_ready;
  logic signed [NCHAN-1:0][MANT_W-1:0]    data_re_in;
  logic signed [NCHAN-1:0][MANT_W-1:0]    data_im_in;
  logic signed [NCHAN-1:0][RES_W-1:0]     data_re_out;
  logic signed [NCHAN-1:0][RES_W-1:0]     data_im_out;
  logic                                   valid_out;
  logic        [$clog2(EXP_DEPTH):0]      exp_count;
  logic                                   err_ovf;
  logic                                   err_udf;

  modport master (
    output exp_valid, exp_idx, valid_in, data_re_in, data_im_in,
    input  exp_ready, in_ready, data_re_out, data_im_out, valid_out,
           exp_count, err_ovf, err_udf
  );

  modport slave (
    input  exp_valid, exp_idx, valid_in, data_re_in, data_im_in,
    output exp_ready, in_ready, data_re_out, data_im_out, valid_out,
           exp_count, err_ovf, err_udf
  );
endinterface

// File: rtl/cbfp_restore.sv
// cbfp_restore
// Inverse of the CBFP normalizer. Per-block shift indices are pushed ahead of
// their data into an in-order exponent FIFO; each accepted mantissa vector pops
// the head entry and every lane is rescaled to the common <12.13> format:
//   idx <= TRUNC_VALUE : out = in <<< (TRUNC_VALUE - idx)
//   idx >  TRUNC_VALUE : out = in >>> (idx - TRUNC_VALUE)   (floor rounding)
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - cbfp_restore_if.slave (handshakes, data, occupancy, sticky errors)
module cbfp_restore #(
  parameter int MANT_W      = 12,
  parameter int RES_W       = 25,
  parameter int NCHAN       = 16,
  parameter int BLOCK_SIZE  = 8,
  parameter int NBLOCKS     = NCHAN / BLOCK_SIZE,
  parameter int TRUNC_VALUE = 13,
  parameter int IDX_W       = $clog2(RES_W),
  parameter int EXP_DEPTH   = 8
) (
  input logic              clk,
  input logic              rst,
  cbfp_restore_if.slave    bus
);

  localparam int PTR_W = $clog2(EXP_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [NBLOCKS-1:0][IDX_W-1:0] exp_entry_t;

  exp_entry_t                         mem [EXP_DEPTH];
  logic [PTR_W-1:0]                   wr_ptr;
  logic [PTR_W-1:0]                   rd_ptr;
  logic [CNT_W-1:0]                   count;
  logic                               full;
  logic                               empty;
  logic                               push;
  logic                               pop;
  exp_entry_t                         head;
  logic signed [NCHAN-1:0][RES_W-1:0] restored_re;
  logic signed [NCHAN-1:0][RES_W-1:0] restored_im;

  // Handshakes depend only on the registered count, so a full FIFO rejects
  // a push even when a pop frees a slot in the same cycle, and an empty FIFO
  // never forwards a same-cycle push to the data path.
  assign full          = (count >= CNT_W'(EXP_DEPTH));
  assign empty         = (count == '0);
  assign bus.exp_ready = !full;
  assign bus.in_ready  = !empty;
  assign push          = bus.exp_valid && !full;
  assign pop           = bus.valid_in && !empty;
  assign bus.exp_count = count;
  assign head          = mem[rd_ptr];

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      bus.err_ovf <= 1'b0;
      bus.err_udf <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.exp_valid && full) bus.err_ovf <= 1'b1;
      if (bus.valid_in && empty) bus.err_udf <= 1'b1;
    end
  end

  // NOTE: the entry storage has no reset; pointers and count are reset, so
  // stale contents are never read, and leaving it out keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.exp_idx;
  end

  // Sign-extend the mantissa to RES_W, then shift toward <12.13>. A left
  // shift never exceeds TRUNC_VALUE, so the 12-bit input always fits.
  function automatic logic signed [RES_W-1:0] restore_lane(
    input logic [MANT_W-1:0] mant,
    input logic [IDX_W-1:0]  idx
  );
    logic signed [RES_W-1:0] ext;
    ext = {{(RES_W-MANT_W){mant[MANT_W-1]}}, mant};
    if (idx <= IDX_W'(TRUNC_VALUE))
      return ext <<< (IDX_W'(TRUNC_VALUE) - idx);
    else
      return ext >>> (idx - IDX_W'(TRUNC_VALUE));
  endfunction

  for (genvar ch = 0; ch < NCHAN; ch++) begin : g_lane
    assign restored_re[ch] = restore_lane(bus.data_re_in[ch], head[ch / BLOCK_SIZE]);
    assign restored_im[ch] = restore_lane(bus.data_im_in[ch], head[ch / BLOCK_SIZE]);
  end

  // Data registers only load on an accepted vector and otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.data_re_out <= '0;
      bus.data_im_out <= '0;
      bus.valid_out   <= 1'b0;
    end else begin
      bus.valid_out <= pop;
      if (pop) begin
        bus.data_re_out <= restored_re;
        bus.data_im_out <= restored_im;
      end
    end
  end

endmodule

// File: tb/tb_cbfp_restore.sv
// tb_cbfp_restore
// Self-checking bench for cbfp_restore: a table of directed vectors, hand
// sequences for full/empty/wrap/reset corners, and a randomized phase checked
// against a queue-based reference model using plain integer arithmetic.
module tb_cbfp_restore;

  localparam int MANT_W      = 12;
  localparam int RES_W       = 25;
  localparam int NCHAN       = 16;
  localparam int BLOCK_SIZE  = 8;
  localparam int NBLOCKS     = NCHAN / BLOCK_SIZE;
  localparam int TRUNC_VALUE = 13;
  localparam int IDX_W       = $clog2(RES_W);
  localparam int EXP_DEPTH   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cbfp_restore_if bus ();
  cbfp_restore dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;

  int     cur_re [NCHAN];
  int     cur_im [NCHAN];
  longint last_re0;

  typedef struct {
    int     e0, e1;
    int     re_a, im_a, re_b, im_b;
    longint x_re_a, x_im_a, x_re_b, x_im_b;
  } vec_t;

  typedef struct { int e0, e1; } ent_t;

  vec_t tbl [5];
  ent_t model_q [$];

  task automatic check(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Reference: value * 2^(13-idx), or floor(value / 2^(idx-13)).
  function automatic longint restore_ref(input int mant, input int idx);
    longint d;
    if (idx <= TRUNC_VALUE) return longint'(mant) * (longint'(1) << (TRUNC_VALUE - idx));
    d = longint'(1) << (idx - TRUNC_VALUE);
    if (mant >= 0) return longint'(mant) / d;
    return -((-longint'(mant) + d - 1) / d);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_lanes();
    for (int ch = 0; ch < NCHAN; ch++) begin
      bus.data_re_in[ch] = MANT_W'(cur_re[ch]);
      bus.data_im_in[ch] = MANT_W'(cur_im[ch]);
    end
  endtask

  task automatic rand_lanes();
    for (int ch = 0; ch < NCHAN; ch++) begin
      cur_re[ch] = int'($urandom_range(0, 4095)) - 2048;
      cur_im[ch] = int'($urandom_range(0, 4095)) - 2048;
    end
    drive_lanes();
  endtask

  task automatic set_idx(input int e0, input int e1);
    bus.exp_idx[0] = IDX_W'(e0);
    bus.exp_idx[1] = IDX_W'(e1);
  endtask

  task automatic push(input int e0, input int e1);
    bus.exp_valid = 1'b1;
    set_idx(e0, e1);
    tick();
    bus.exp_valid = 1'b0;
  endtask

  // Compares all 32 lane values against the model; reports the first mismatch.
  task automatic check_out(input string name, input int e0, input int e1);
    longint got_v, want_v;
    bit     found;
    found  = 1'b0;
    got_v  = longint'($signed(bus.data_re_out[0]));
    want_v = restore_ref(cur_re[0], e0);
    for (int ch = 0; ch < NCHAN; ch++) begin
      int     idx = (ch / BLOCK_SIZE == 0) ? e0 : e1;
      longint wr  = restore_ref(cur_re[ch], idx);
      longint wi  = restore_ref(cur_im[ch], idx);
      longint gr  = longint'($signed(bus.data_re_out[ch]));
      longint gi  = longint'($signed(bus.data_im_out[ch]));
      if (!found && gr != wr) begin found = 1'b1; got_v = gr; want_v = wr; end
      if (!found && gi != wi) begin found = 1'b1; got_v = gi; want_v = wi; end
    end
    last_re0 = restore_ref(cur_re[0], e0);
    check(name, got_v, want_v);
  endtask

  initial begin
    tbl[0] = '{13, 13,   100, -100,   100, -100,        100,     -100,       100,    -100};
    tbl[1] = '{10, 20,     5,    0,    -3,    0,         40,        0,        -1,       0};
    tbl[2] = '{ 0,  0, -2048, 2047, -2048, 2047, -16777216, 16769024, -16777216, 16769024};
    tbl[3] = '{31, 14,    -1,    1,     7,   -7,         -1,        0,         3,      -4};
    tbl[4] = '{13,  0,  2047, -2048,    1,   -1,       2047,    -2048,      8192,   -8192};

    bus.exp_valid  = 1'b0;
    bus.valid_in   = 1'b0;
    bus.exp_idx    = '0;
    bus.data_re_in = '0;
    bus.data_im_in = '0;
    for (int ch = 0; ch < NCHAN; ch++) begin cur_re[ch] = 0; cur_im[ch] = 0; end
    last_re0 = 0;

    // Reset state
    #12;
    check("rst_count",     bus.exp_count, 0);
    check("rst_exp_ready", bus.exp_ready, 1);
    check("rst_in_ready",  bus.in_ready,  0);
    check("rst_valid_out", bus.valid_out, 0);
    check("rst_data",      longint'($signed(bus.data_re_out[0])), 0);
    check("rst_err_ovf",   bus.err_ovf,   0);
    check("rst_err_udf",   bus.err_udf,   0);
    rst = 1'b0;
    tick();

    // Directed table
    for (int t = 0; t < 5; t++) begin
      push(tbl[t].e0, tbl[t].e1);
      check("tbl_count_after_push", bus.exp_count, 1);
      check("tbl_in_ready",         bus.in_ready,  1);
      for (int ch = 0; ch < NCHAN; ch++) begin
        cur_re[ch] = (ch < BLOCK_SIZE) ? tbl[t].re_a : tbl[t].re_b;
        cur_im[ch] = (ch < BLOCK_SIZE) ? tbl[t].im_a : tbl[t].im_b;
      end
      drive_lanes();
      bus.valid_in = 1'b1;
      tick();
      bus.valid_in = 1'b0;
      check("tbl_valid_out", bus.valid_out, 1);
      check("tbl_re_lane0",  longint'($signed(bus.data_re_out[0])), tbl[t].x_re_a);
      check("tbl_im_lane0",  longint'($signed(bus.data_im_out[0])), tbl[t].x_im_a);
      check("tbl_re_lane8",  longint'($signed(bus.data_re_out[8])), tbl[t].x_re_b);
      check("tbl_im_lane8",  longint'($signed(bus.data_im_out[8])), tbl[t].x_im_b);
      check_out("tbl_all_lanes", tbl[t].e0, tbl[t].e1);
      check("tbl_count_after_pop", bus.exp_count, 0);
      tick();
      check("tbl_valid_pulse", bus.valid_out, 0);
      check("tbl_hold", longint'($signed(bus.data_re_out[0])), tbl[t].x_re_a);
    end

    // Fill, overflow, push-while-full-with-pop, wrap, back-to-back outputs
    for (int i = 0; i < EXP_DEPTH; i++) push(6 + i, 13 + i);
    check("full_count",     bus.exp_count, 8);
    check("full_exp_ready", bus.exp_ready, 0);
    check("full_err_ovf_0", bus.err_ovf,   0);
    push(1, 1);
    check("ovf_err",   bus.err_ovf,   1);
    check("ovf_count", bus.exp_count, 8);
    for (int k = 0; k < EXP_DEPTH; k++) begin
      rand_lanes();
      bus.valid_in  = 1'b1;
      bus.exp_valid = (k == 0);
      set_idx(2, 2);
      tick();
      bus.exp_valid = 1'b0;
      check("wrap_valid_out", bus.valid_out, 1);
      check_out("wrap_vec", 6 + k, 13 + k);
      if (k == 0) check("full_push_pop_count", bus.exp_count, 7);
    end
    bus.valid_in = 1'b0;
    check("drain_count",    bus.exp_count, 0);
    check("drain_in_ready", bus.in_ready,  0);

    // Underflow
    check("udf_err_0", bus.err_udf, 0);
    rand_lanes();
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    check("udf_valid_out", bus.valid_out, 0);
    check("udf_err",       bus.err_udf,   1);
    check("udf_hold",      longint'($signed(bus.data_re_out[0])), last_re0);

    // Simultaneous push and pop at count 3
    push(13, 13);
    push(12, 14);
    push(11, 15);
    check("pp_count_before", bus.exp_count, 3);
    rand_lanes();
    bus.exp_valid = 1'b1;
    set_idx(9, 9);
    bus.valid_in = 1'b1;
    tick();
    bus.exp_valid = 1'b0;
    bus.valid_in  = 1'b0;
    check("pp_count_after", bus.exp_count, 3);
    check("pp_valid_out",   bus.valid_out, 1);
    check_out("pp_vec", 13, 13);
    begin
      ent_t order [3];
      order[0] = '{12, 14};
      order[1] = '{11, 15};
      order[2] = '{9, 9};
      for (int k = 0; k < 3; k++) begin
        rand_lanes();
        bus.valid_in = 1'b1;
        tick();
        check_out("pp_drain_vec", order[k].e0, order[k].e1);
      end
      bus.valid_in = 1'b0;
    end
    check("pp_drain_count", bus.exp_count, 0);

    // Randomized phase against the queue model
    model_q.delete();
    for (int c = 0; c < 400; c++) begin
      bit   pv, vv, push_ok, pop_ok;
      ent_t ent, popped;
      pv = ($urandom_range(0, 99) < ((c < 200) ? 70 : 30));
      vv = ($urandom_range(0, 99) < ((c < 200) ? 40 : 75));
      ent.e0 = int'($urandom_range(0, 31));
      ent.e1 = int'($urandom_range(0, 31));
      rand_lanes();
      bus.exp_valid = pv;
      set_idx(ent.e0, ent.e1);
      bus.valid_in = vv;
      check("rnd_exp_ready", bus.exp_ready, longint'(model_q.size() < EXP_DEPTH));
      check("rnd_in_ready",  bus.in_ready,  longint'(model_q.size() != 0));
      push_ok = pv && (model_q.size() < EXP_DEPTH);
      pop_ok  = vv && (model_q.size() != 0);
      popped  = '{0, 0};
      if (pop_ok)  popped = model_q.pop_front();
      if (push_ok) model_q.push_back(ent);
      tick();
      check("rnd_valid_out", bus.valid_out, longint'(pop_ok));
      if (pop_ok) check_out("rnd_vec", popped.e0, popped.e1);
      check("rnd_count", bus.exp_count, model_q.size());
    end
    bus.exp_valid = 1'b0;
    bus.valid_in  = 1'b0;
    while (model_q.size() != 0) begin
      ent_t popped;
      popped = model_q.pop_front();
      rand_lanes();
      bus.valid_in = 1'b1;
      tick();
      check_out("rnd_drain_vec", popped.e0, popped.e1);
    end
    bus.valid_in = 1'b0;
    tick();

    // Reset mid-stream with count 4 and an output just produced
    for (int i = 0; i < 5; i++) push(10 + i, 14 + i);
    cur_re[0] = 1000;
    drive_lanes();
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    check("mid_count", bus.exp_count, 4);
    check("mid_data_before", longint'($signed(bus.data_re_out[0])), 8000);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_count",     bus.exp_count, 0);
    check("mid_rst_in_ready",  bus.in_ready,  0);
    check("mid_rst_valid_out", bus.valid_out, 0);
    check("mid_rst_data",      longint'($signed(bus.data_re_out[0])), 0);
    check("mid_rst_err_ovf",   bus.err_ovf,   0);
    check("mid_rst_err_udf",   bus.err_udf,   0);
    @(negedge clk);
    rst = 1'b0;
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    check("post_rst_no_output", bus.valid_out, 0);
    check("post_rst_udf",       bus.err_udf,   1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
